id_pipe_stage: RTL and testbench
================================

// Module: id_pipe_stage
// PURPOSE
//  Pipelined RV32I decode stage between IF and EX: decodes, reads the regfile (WB write-through), detects hazards, holds the ID/EX register.
//  Valid/ready handshake both sides; load-use or interlock stalls; branch/jump flush from EX.
//  Replaces the single-cycle decode path; WB result mux moves to the WB stage.
// PARAMETERS
//  XLEN     32  datapath/register width
//  NREGS    32  architectural registers; x0 hardwired 0; address width AW=$clog2(NREGS)
//  FWD_EN   1   1: EX forwards, stall only on load-use; 0: full interlock vs EX and MEM producers
//  RST_PC   0   id_pc value under reset
// PORTS
//  clk          in   1     clock
//  reset        in   1     async, active-low; clears pipeline reg and regfile
//  if_valid     in   1     IF presents an instruction
//  if_instr     in   32    instruction word
//  if_pc        in   XLEN  PC of if_instr
//  if_ready     out  1     ID accepts this cycle
//  flush        in   1     EX redirect; kill ID contents and the incoming instruction
//  ex_ready     in   1     EX accepts ID/EX register
//  ex_valid     in   1     EX holds a live instruction
//  ex_rd        in   AW    EX destination; ex_we/ex_is_load in 1 each
//  mem_valid    in   1     MEM holds a live instruction; mem_rd in AW, mem_we in 1
//  wb_we        in   1     WB write enable; wb_rd in AW; wb_data in XLEN
//  id_valid     out  1     ID/EX register live
//  id_pc        out  XLEN  PC; id_pc4 out XLEN = PC+4
//  id_rs1/id_rs2 out XLEN  operand data; id_rs1_addr/id_rs2_addr out AW (for EX forwarding)
//  id_imm       out  XLEN  sign-extended immediate; id_rd out AW
//  id_ctrl      out  ctrl_t opcode, funct3/7, op1_sel, op2_sel, jump_sel, mem_we, reg_we, reg_src[1:0]
//  debug_en     in   1     debug read; debug_addr in AW; debug_data out XLEN (combinational)
// BEHAVIOUR
//  Reset (reset=0, async): id_valid=0, id_ctrl all 0, id_pc=RST_PC, data outputs 0, regfile 0.
//  Regfile: write on posedge when wb_we && wb_rd!=0. A same-cycle read of wb_rd returns wb_data.
//  Reads of x0 always return 0.
//  Source use: rs1 used unless LUI/AUIPC/JAL; rs2 used only for R, S, B.
//  hazard (FWD_EN=1): ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches a used source.
//  hazard (FWD_EN=0): a used source !=0 matches (ex_valid&&ex_we&&ex_rd), or (mem_valid&&mem_we&&mem_rd).
//  advance = !id_valid || ex_ready. if_ready = advance && !hazard && !flush.
//  Each clock, in priority order:
//   1. flush: id_valid<=0.
//   2. else if advance && hazard: id_valid<=0 (bubble); IF holds the instruction.
//   3. else if advance: load register from if_*; id_valid<=if_valid.
//   4. else (!ex_ready && id_valid): hold all outputs stable.
//  Latency: instruction accepted at edge N is presented at N+1. Throughput 1/cycle with no hazards.
//  Illegal opcode: id_valid=1, id_ctrl zero (NOP; reg_we=0, mem_we=0). No trap in this revision.
//  id_pc4 wraps modulo 2^XLEN. Immediates are sign-extended from bit 31 to XLEN.
//  Flush during stall: flush wins; the stalled instruction is dropped by IF via redirect.
//  reset deassertion mid-stream: first accept no earlier than the first edge after release.
// STRUCTURE
//  Package id_pkg: ctrl_t struct, opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
//   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), reg_src_e {SRC_ALU, SRC_PC4, SRC_MEM}.
//  Reuse the existing RegFile, inst_decoder, and control_unit.
//  New sub-module: id_hazard_unit (source-use decode + hazard compare, parameterised by FWD_EN).
// TESTING
//  1. Reset, then stream addi x1,x0,5 / addi x2,x0,7 with ex_ready=1 -> id_valid from cycle 1; id_imm=5 then 7; no stall.
//  2. FWD_EN=1, EX holds lw x3 (ex_is_load=1); ID decodes add x4,x3,x1 -> if_ready=0 one cycle, bubble; then add issues.
//  3. FWD_EN=0, add x5,x1,x2 with mem_rd=2, mem_we=1 -> stall until mem_valid drops; add x5 with x0 source -> no stall.
//  4. WB writes x6=0xDEADBEEF while ID reads x6 same cycle -> id_rs1=0xDEADBEEF. WB to x0 -> x0 reads 0.
//  5. ex_ready=0 for 3 cycles with id_valid=1 -> all outputs stable, if_ready=0; flush during stall -> id_valid=0 next cycle.
//  6. reset asserted mid-stream -> id_valid=0 immediately (async); x1 reads 0 after release; if_pc=0xFFFFFFFC -> id_pc4=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage types: control bundle, RV32I opcodes, writeback source select.
// Imported by the ID stage, its hazard unit and the bench.
package id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_PC4 = 2'd1,
    SRC_MEM = 2'd2
  } reg_src_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       op1_sel;
    logic       op2_sel;
    logic       jump_sel;
    logic       mem_we;
    logic       reg_we;
    reg_src_e   reg_src;
  } ctrl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Source-use decode and producer compare for the ID stage.
// FWD_EN!=0 stalls only on load-use; otherwise interlocks on any EX/MEM writer.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int AW     = 5,
  parameter int FWD_EN = 1
) (
  input  logic [6:0]    opcode,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic          mem_valid,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_rd,
  output logic          hazard
);

  logic use1;
  logic use2;
  logic ex_hit;
  logic mem_hit;
  logic load_haz;
  logic lock_haz;

  assign use1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign use2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};

  assign ex_hit = (ex_rd != '0) &&
                  ((use1 && rs1 == ex_rd) ||
                   (use2 && rs2 == ex_rd));

  assign mem_hit = (mem_rd != '0) &&
                   ((use1 && rs1 == mem_rd) ||
                    (use2 && rs2 == mem_rd));

  assign load_haz = ex_valid && ex_is_load && ex_hit;

  assign lock_haz = (ex_valid && ex_we && ex_hit) ||
                    (mem_valid && mem_we && mem_hit);

  assign hazard = (FWD_EN != 0) ? load_haz : lock_haz;

endmodule

// File: rtl/id_pipe_stage.sv
// RV32I decode stage: regfile with WB write-through, decode, hazard stall,
// and the ID/EX register behind a valid/ready handshake.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              NREGS  = 32,
  parameter int              FWD_EN = 1,
  parameter logic [XLEN-1:0] RST_PC = '0,
  localparam int             AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic            mem_we,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [XLEN-1:0] id_rs1,
  output logic [XLEN-1:0] id_rs2,
  output logic [AW-1:0]   id_rs1_addr,
  output logic [AW-1:0]   id_rs2_addr,
  output logic [XLEN-1:0] id_imm,
  output logic [AW-1:0]   id_rd,
  output ctrl_t           id_ctrl,
  input  logic            debug_en,
  input  logic [AW-1:0]   debug_addr,
  output logic [XLEN-1:0] debug_data
);

  logic [XLEN-1:0] rf [NREGS];
  logic [6:0]      opc;
  logic [AW-1:0]   rs1_a;
  logic [AW-1:0]   rs2_a;
  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;
  logic [XLEN-1:0] dbg_d;
  logic [31:0]     i_imm;
  logic [31:0]     s_imm;
  logic [31:0]     b_imm;
  logic [31:0]     u_imm;
  logic [31:0]     j_imm;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  ctrl_t           ctrl;
  logic            legal;
  logic            hazard;
  logic            advance;

  assign opc   = if_instr[6:0];
  assign rd_a  = AW'(if_instr[11:7]);
  assign rs1_a = AW'(if_instr[19:15]);
  assign rs2_a = AW'(if_instr[24:20]);

  // WB bypass: a read of the register being written this cycle sees the new value
  assign rs1_d = (rs1_a == '0) ? '0 :
                 (wb_we && wb_rd == rs1_a) ? wb_data : rf[rs1_a];
  assign rs2_d = (rs2_a == '0) ? '0 :
                 (wb_we && wb_rd == rs2_a) ? wb_data : rf[rs2_a];
  assign dbg_d = (debug_addr == '0) ? '0 :
                 (wb_we && wb_rd == debug_addr) ? wb_data : rf[debug_addr];

  assign debug_data = debug_en ? dbg_d : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign i_imm = {{20{if_instr[31]}}, if_instr[31:20]};
  assign s_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign b_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};
  assign u_imm = {if_instr[31:12], 12'b0};
  assign j_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                  if_instr[20], if_instr[30:21], 1'b0};

  assign legal = opc inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                             OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  always_comb begin
    ctrl  = '0;
    imm32 = '0;
    unique case (1'b1)
      opc == OP_R: begin
        ctrl.reg_we = 1'b1;
      end
      opc == OP_I: begin
        ctrl.op2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm32        = i_imm;
      end
      opc == OP_LOAD: begin
        ctrl.op2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.reg_src = SRC_MEM;
        imm32        = i_imm;
      end
      opc == OP_STORE: begin
        ctrl.op2_sel = 1'b1;
        ctrl.mem_we  = 1'b1;
        imm32        = s_imm;
      end
      opc == OP_BRANCH: begin
        imm32 = b_imm;
      end
      opc == OP_JAL: begin
        ctrl.op1_sel  = 1'b1;
        ctrl.op2_sel  = 1'b1;
        ctrl.jump_sel = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.reg_src  = SRC_PC4;
        imm32         = j_imm;
      end
      opc == OP_JALR: begin
        ctrl.op2_sel  = 1'b1;
        ctrl.jump_sel = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.reg_src  = SRC_PC4;
        imm32         = i_imm;
      end
      opc == OP_LUI: begin
        ctrl.op2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm32        = u_imm;
      end
      opc == OP_AUIPC: begin
        ctrl.op1_sel = 1'b1;
        ctrl.op2_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm32        = u_imm;
      end
      default: ;
    endcase
    // Unknown opcodes leave the whole bundle zero, i.e. a NOP
    if (legal) begin
      ctrl.opcode = opc;
      ctrl.funct3 = if_instr[14:12];
      ctrl.funct7 = if_instr[31:25];
    end
  end

  assign imm = XLEN'($signed(imm32));

  id_hazard_unit #(
    .AW     (AW),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .opcode     (opc),
    .rs1        (rs1_a),
    .rs2        (rs2_a),
    .ex_valid   (ex_valid),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .hazard     (hazard)
  );

  assign advance  = !id_valid || ex_ready;
  assign if_ready = advance && !hazard && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid    <= 1'b0;
      id_pc       <= RST_PC;
      id_pc4      <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rs1_addr <= '0;
      id_rs2_addr <= '0;
      id_imm      <= '0;
      id_rd       <= '0;
      id_ctrl     <= '0;
    end else if (flush || (advance && hazard)) begin
      id_valid <= 1'b0;
    end else if (advance) begin
      id_valid    <= if_valid;
      id_pc       <= if_pc;
      id_pc4      <= if_pc + XLEN'(4);
      id_rs1      <= rs1_d;
      id_rs2      <= rs2_d;
      id_rs1_addr <= rs1_a;
      id_rs2_addr <= rs2_a;
      id_imm      <= imm;
      id_rd       <= rd_a;
      id_ctrl     <= ctrl;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: forwarding and interlock builds side by side,
// checked against an instruction-level reference model.
module tb_id_pipe_stage;
  import id_pkg::*;

  localparam logic [31:0] RSTPC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_is_load;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_we;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        debug_en;
  logic [4:0]  debug_addr;

  logic        if_ready_o [2];
  logic        id_valid_o [2];
  logic [31:0] id_pc_o    [2];
  logic [31:0] id_pc4_o   [2];
  logic [31:0] id_rs1_o   [2];
  logic [31:0] id_rs2_o   [2];
  logic [4:0]  id_r1a_o   [2];
  logic [4:0]  id_r2a_o   [2];
  logic [31:0] id_imm_o   [2];
  logic [4:0]  id_rd_o    [2];
  ctrl_t       id_ctrl_o  [2];
  logic [31:0] dbg_o      [2];

  int n_checks;
  int n_errors;

  // reference state: one regfile, one ID slot per build
  logic [31:0] mrf    [32];
  bit          mv     [2];
  logic [31:0] mpc    [2];
  logic [31:0] minstr [2];
  logic [31:0] mr1    [2];
  logic [31:0] mr2    [2];

  logic [6:0] ops [10];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_pipe_stage #(
      .XLEN   (32),
      .NREGS  (32),
      .FWD_EN (g),
      .RST_PC (RSTPC)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_ready    (if_ready_o[g]),
      .flush       (flush),
      .ex_ready    (ex_ready),
      .ex_valid    (ex_valid),
      .ex_rd       (ex_rd),
      .ex_we       (ex_we),
      .ex_is_load  (ex_is_load),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .mem_we      (mem_we),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .id_valid    (id_valid_o[g]),
      .id_pc       (id_pc_o[g]),
      .id_pc4      (id_pc4_o[g]),
      .id_rs1      (id_rs1_o[g]),
      .id_rs2      (id_rs2_o[g]),
      .id_rs1_addr (id_r1a_o[g]),
      .id_rs2_addr (id_r2a_o[g]),
      .id_imm      (id_imm_o[g]),
      .id_rd       (id_rd_o[g]),
      .id_ctrl     (id_ctrl_o[g]),
      .debug_en    (debug_en),
      .debug_addr  (debug_addr),
      .debug_data  (dbg_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    int sh;
    sh = 32 - bits;
    return 32'($signed(v << sh) >>> sh);
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == OP_I || op == OP_LOAD || op == OP_JALR)
      return sext(ins >> 20, 12);
    if (op == OP_STORE)
      return sext(32'({ins[31:25], ins[11:7]}), 12);
    if (op == OP_BRANCH)
      return sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
    if (op == OP_JAL)
      return sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
    if (op == OP_LUI || op == OP_AUIPC)
      return ins & 32'hFFFF_F000;
    return 32'h0;
  endfunction

  function automatic ctrl_t exp_ctrl(input logic [31:0] ins);
    ctrl_t c;
    logic [6:0] op;
    bit ok;
    c  = '0;
    op = ins[6:0];
    ok = 1'b1;
    case (op)
      OP_R:      c.reg_we = 1'b1;
      OP_I:      begin c.op2_sel = 1'b1; c.reg_we = 1'b1; end
      OP_LOAD:   begin c.op2_sel = 1'b1; c.reg_we = 1'b1; c.reg_src = SRC_MEM; end
      OP_STORE:  begin c.op2_sel = 1'b1; c.mem_we = 1'b1; end
      OP_BRANCH: ;
      OP_JAL:    begin c.op1_sel = 1'b1; c.op2_sel = 1'b1; c.jump_sel = 1'b1;
                       c.reg_we = 1'b1; c.reg_src = SRC_PC4; end
      OP_JALR:   begin c.op2_sel = 1'b1; c.jump_sel = 1'b1;
                       c.reg_we = 1'b1; c.reg_src = SRC_PC4; end
      OP_LUI:    begin c.op2_sel = 1'b1; c.reg_we = 1'b1; end
      OP_AUIPC:  begin c.op1_sel = 1'b1; c.op2_sel = 1'b1; c.reg_we = 1'b1; end
      default:   ok = 1'b0;
    endcase
    if (ok) begin
      c.opcode = op;
      c.funct3 = ins[14:12];
      c.funct7 = ins[31:25];
    end
    return c;
  endfunction

  function automatic logic [31:0] rdm(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && wb_rd == a) return wb_data;
    return mrf[a];
  endfunction

  function automatic bit exp_haz(input int k, input logic [31:0] ins);
    logic [6:0] op;
    logic [4:0] s [$];
    bit hit_ex, hit_mem;
    op = ins[6:0];
    if (!(op == OP_LUI || op == OP_AUIPC || op == OP_JAL)) s.push_back(ins[19:15]);
    if (op == OP_R || op == OP_STORE || op == OP_BRANCH) s.push_back(ins[24:20]);
    hit_ex  = 1'b0;
    hit_mem = 1'b0;
    foreach (s[i]) begin
      if (s[i] != 0 && s[i] == ex_rd)  hit_ex  = 1'b1;
      if (s[i] != 0 && s[i] == mem_rd) hit_mem = 1'b1;
    end
    if (k == 1) return ex_valid && ex_is_load && hit_ex;
    return (ex_valid && ex_we && hit_ex) || (mem_valid && mem_we && hit_mem);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    for (int k = 0; k < 2; k++) mv[k] = 1'b0;
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.valid", k), 32'(id_valid_o[k]), 32'(mv[k]));
      if (mv[k]) begin
        chk($sformatf("d%0d.pc", k), id_pc_o[k], mpc[k]);
        chk($sformatf("d%0d.pc4", k), id_pc4_o[k], mpc[k] + 32'd4);
        chk($sformatf("d%0d.rs1", k), id_rs1_o[k], mr1[k]);
        chk($sformatf("d%0d.rs2", k), id_rs2_o[k], mr2[k]);
        chk($sformatf("d%0d.rs1a", k), 32'(id_r1a_o[k]), 32'(minstr[k][19:15]));
        chk($sformatf("d%0d.rs2a", k), 32'(id_r2a_o[k]), 32'(minstr[k][24:20]));
        chk($sformatf("d%0d.rd", k), 32'(id_rd_o[k]), 32'(minstr[k][11:7]));
        chk($sformatf("d%0d.imm", k), id_imm_o[k], exp_imm(minstr[k]));
        chk($sformatf("d%0d.ctrl", k), 32'(id_ctrl_o[k]), 32'(exp_ctrl(minstr[k])));
      end
    end
  endtask

  // inputs are set before the call; compares comb outputs, clocks, compares regs
  task automatic tick();
    bit hz [2];
    bit adv [2];
    logic [31:0] r1, r2;
    #1;
    r1 = rdm(if_instr[19:15]);
    r2 = rdm(if_instr[24:20]);
    for (int k = 0; k < 2; k++) begin
      adv[k] = !mv[k] || ex_ready;
      hz[k]  = exp_haz(k, if_instr);
      chk($sformatf("d%0d.if_ready", k), 32'(if_ready_o[k]),
          32'(adv[k] && !hz[k] && !flush));
      if (debug_en) chk($sformatf("d%0d.debug", k), dbg_o[k], rdm(debug_addr));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush || (adv[k] && hz[k])) begin
        mv[k] = 1'b0;
      end else if (adv[k]) begin
        mv[k]     = if_valid;
        mpc[k]    = if_pc;
        minstr[k] = if_instr;
        mr1[k]    = r1;
        mr2[k]    = r2;
      end
    end
    if (wb_we && wb_rd != 0) mrf[wb_rd] = wb_data;
    @(negedge clk);
    check_regs();
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {imm, rs1, 3'd0, rd, OP_I};
  endfunction

  task automatic quiet();
    flush = 0; ex_ready = 1; ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 0; mem_we = 0; mem_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  logic [31:0] held_pc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h73};
    if_valid = 0; if_instr = 0; if_pc = 0;
    debug_en = 1; debug_addr = 0;
    quiet();
    reset = 1;
    #2 reset = 0;
    mreset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.rst_valid", k), 32'(id_valid_o[k]), 32'd0);
      chk($sformatf("d%0d.rst_pc", k), id_pc_o[k], RSTPC);
      chk($sformatf("d%0d.rst_pc4", k), id_pc4_o[k], 32'd0);
      chk($sformatf("d%0d.rst_imm", k), id_imm_o[k], 32'd0);
      chk($sformatf("d%0d.rst_ctrl", k), 32'(id_ctrl_o[k]), 32'd0);
    end
    reset = 1;

    // addi stream, one per cycle
    if_valid = 1; if_pc = 32'h200; if_instr = enc_i(12'd5, 5'd0, 5'd1);
    tick();
    chk("t1.imm5", id_imm_o[1], 32'd5);
    if_pc = 32'h204; if_instr = enc_i(12'd7, 5'd0, 5'd2);
    tick();
    chk("t1.imm7", id_imm_o[1], 32'd7);
    chk("t1.valid", 32'(id_valid_o[1]), 32'd1);

    // load-use on the forwarding build
    ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 3;
    if_pc = 32'h208; if_instr = enc_r(5'd1, 5'd3, 5'd4);
    #1 chk("t2.stall", 32'(if_ready_o[1]), 32'd0);
    tick();
    chk("t2.bubble", 32'(id_valid_o[1]), 32'd0);
    ex_valid = 0; ex_is_load = 0; ex_we = 0;
    tick();
    chk("t2.issue", 32'(id_rd_o[1]), 32'd4);

    // MEM interlock on the non-forwarding build
    mem_valid = 1; mem_we = 1; mem_rd = 2;
    if_pc = 32'h20C; if_instr = enc_r(5'd2, 5'd1, 5'd5);
    #1 chk("t3.lock", 32'(if_ready_o[0]), 32'd0);
    chk("t3.fwd_free", 32'(if_ready_o[1]), 32'd1);
    tick();
    tick();
    mem_valid = 0;
    tick();
    chk("t3.issue", 32'(id_valid_o[0]), 32'd1);
    mem_valid = 1; mem_rd = 0; if_instr = enc_r(5'd0, 5'd0, 5'd5);
    #1 chk("t3.x0", 32'(if_ready_o[0]), 32'd1);
    tick();
    quiet();

    // WB write-through, and writes to x0 are dropped
    wb_we = 1; wb_rd = 6; wb_data = 32'hDEAD_BEEF;
    if_pc = 32'h210; if_instr = enc_i(12'd0, 5'd6, 5'd7);
    tick();
    chk("t4.bypass", id_rs1_o[1], 32'hDEAD_BEEF);
    wb_rd = 0; wb_data = 32'h1234_5678; if_instr = enc_r(5'd0, 5'd0, 5'd8);
    tick();
    wb_we = 0; debug_addr = 0;
    tick();
    chk("t4.x0", dbg_o[1], 32'd0);

    // EX back-pressure, then flush during the stall
    if_pc = 32'h300; if_instr = enc_i(12'h7FF, 5'd6, 5'd9);
    tick();
    held_pc = id_pc_o[1];
    ex_ready = 0;
    if_pc = 32'h304; if_instr = enc_i(12'h001, 5'd1, 5'd10);
    for (int i = 0; i < 3; i++) tick();
    chk("t5.hold_pc", id_pc_o[1], 32'h300);
    chk("t5.hold_saved", id_pc_o[1], held_pc);
    flush = 1;
    tick();
    chk("t5.flush", 32'(id_valid_o[1]), 32'd0);
    quiet();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      if_instr   = ins;
      if_valid   = ($urandom_range(0, 3) != 0);
      if_pc      = $urandom & 32'hFFFF_FFFC;
      ex_ready   = ($urandom_range(0, 4) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      ex_valid   = $urandom_range(0, 1) == 1;
      ex_we      = $urandom_range(0, 1) == 1;
      ex_is_load = $urandom_range(0, 1) == 1;
      ex_rd      = 5'($urandom_range(0, 7));
      mem_valid  = $urandom_range(0, 1) == 1;
      mem_we     = $urandom_range(0, 1) == 1;
      mem_rd     = 5'($urandom_range(0, 7));
      wb_we      = $urandom_range(0, 1) == 1;
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      debug_addr = 5'($urandom_range(0, 7));
      tick();
    end
    quiet();

    // async reset mid-stream, then PC+4 wrap
    wb_we = 1; wb_rd = 1; wb_data = 32'h55;
    if_valid = 1; if_pc = 32'h400; if_instr = enc_i(12'd3, 5'd1, 5'd2);
    tick();
    wb_we = 0;
    tick();
    reset = 0;
    #1;
    mreset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.t6_valid", k), 32'(id_valid_o[k]), 32'd0);
      chk($sformatf("d%0d.t6_pc", k), id_pc_o[k], RSTPC);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    debug_addr = 1;
    if_pc = 32'hFFFF_FFFC; if_instr = enc_i(12'd1, 5'd1, 5'd3);
    tick();
    chk("t6.x1", dbg_o[1], 32'd0);
    chk("t6.rs1", id_rs1_o[1], 32'd0);
    chk("t6.pc4", id_pc4_o[1], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
